// File: rtl/frc_div_seq_if.sv
// Handshake bundle for the sequential fraction divider.
// master: operand source / result sink; slave: the divider.
interface frc_div_seq_if #(
    parameter int FW = 23
);
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] frc_X;
    logic [FW-1:0] frc_Y;
    logic          out_valid;
    logic          out_ready;
    logic [FW+2:0] frc_Q;
    logic          sticky;

    modport master (
        output in_valid, frc_X, frc_Y, out_ready,
        input  in_ready, out_valid, frc_Q, sticky
    );

    modport slave (
        input  in_valid, frc_X, frc_Y, out_ready,
        output in_ready, out_valid, frc_Q, sticky
    );
endinterface

// File: rtl/frc_div_seq.sv
// Radix-2 restoring divider: {1,X}/{1,Y} -> 1 int bit, FW+2 frac bits, sticky.
// Ports: clk, rst (sync, active high), io (slave: in/out valid-ready, X, Y, Q, sticky).
module frc_div_seq #(
    parameter int FW = 23
) (
    input  logic         clk,
    input  logic         rst,
    frc_div_seq_if.slave io
);
    localparam int RW = FW + 2;
    localparam int QW = FW + 3;
    localparam int CW = $clog2(QW);
    localparam logic [CW-1:0] LAST = CW'(FW + 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW:0]   b_q, b_d;
    logic [RW-1:0] r_q, r_d;
    logic [QW-1:0] q_q, q_d;
    logic [QW-1:0] frc_q_q, frc_q_d;
    logic          sticky_q, sticky_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [RW-1:0] r_sh;
    logic [RW-1:0] r_nx;
    logic          q_bit;

    // Cycle 0 produces the integer bit without shifting; later cycles
    // double R first. R < B holds afterwards, so the shift never overflows.
    always_comb begin
        r_sh  = (cnt_q == '0) ? r_q : {r_q[RW-2:0], 1'b0};
        q_bit = (r_sh >= {1'b0, b_q});
        r_nx  = q_bit ? (r_sh - {1'b0, b_q}) : r_sh;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        b_d         = b_q;
        r_d         = r_q;
        q_d         = q_q;
        frc_q_d     = frc_q_q;
        sticky_d    = sticky_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    b_d        = {1'b1, io.frc_Y};
                    r_d        = {2'b01, io.frc_X};
                    q_d        = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                r_d   = r_nx;
                q_d   = {q_q[QW-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    frc_q_d     = {q_q[QW-2:0], q_bit};
                    sticky_d    = |r_nx;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            b_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            frc_q_q     <= '0;
            sticky_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            b_q         <= b_d;
            r_q         <= r_d;
            q_q         <= q_d;
            frc_q_q     <= frc_q_d;
            sticky_q    <= sticky_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.frc_Q     = frc_q_q;
    assign io.sticky    = sticky_q;
endmodule

// File: tb/tb_frc_div_seq.sv
// Directed + random bench for frc_div_seq with a result scoreboard.
// Expected quotients come from constants or an integer-division model.
module tb_frc_div_seq;
    localparam int FW = 23;
    localparam int QW = FW + 3;

    typedef struct packed {
        logic [QW-1:0] q;
        logic          s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errs = 0;
    exp_t sb[$];

    frc_div_seq_if #(.FW(FW)) dif ();

    frc_div_seq #(.FW(FW)) dut (
        .clk(clk),
        .rst(rst),
        .io (dif.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [FW-1:0] x,
                                   input logic [FW-1:0] y);
        logic [63:0] num;
        logic [63:0] den;
        logic [63:0] quo;
        exp_t e;
        num = {40'd0, 1'b1, x} << (FW + 2);
        den = {40'd0, 1'b1, y};
        quo = num / den;
        e.q = quo[QW-1:0];
        e.s = ((num % den) != 64'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: pop on every completed output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && dif.out_valid && dif.out_ready) begin
            n_checks++;
            assert (sb.size() > 0) else begin
                n_errs++;
                $error("FAIL unexpected_result observed=%h expected=none",
                       dif.frc_Q);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                assert (dif.frc_Q === e.q) else begin
                    n_errs++;
                    $error("FAIL result_q observed=%h expected=%h",
                           dif.frc_Q, e.q);
                end
                n_checks++;
                assert (dif.sticky === e.s) else begin
                    n_errs++;
                    $error("FAIL result_sticky observed=%b expected=%b",
                           dif.sticky, e.s);
                end
            end
        end
    end

    // Present operands until accepted; push the expected result at the accept edge.
    task automatic send(input logic [FW-1:0] x, input logic [FW-1:0] y,
                        input bit use_model, input logic [QW-1:0] eq,
                        input logic es);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        e  = use_model ? model(x, y) : '{q: eq, s: es};
        @(posedge clk);
        #1;
        dif.frc_X    = x;
        dif.frc_Y    = y;
        dif.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (dif.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        if (ok) sb.push_back(e);
        #1;
        dif.in_valid = 1'b0;
    endtask

    // Wait until the scoreboard is empty, optionally stalling out_ready.
    task automatic drain(input bit stall);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            dif.out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        dif.out_ready = 1'b1;
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int   lat;
        int   seen;
        exp_t bp;
        dif.in_valid  = 1'b0;
        dif.frc_X     = '0;
        dif.frc_Y     = '0;
        dif.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(dif.in_ready), 32'd1);
        chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
        chk("rst_frc_q", 32'(dif.frc_Q), 32'd0);
        chk("rst_sticky", 32'(dif.sticky), 32'd0);

        // 1.0/1.0 plus latency
        send(23'h0, 23'h0, 1'b0, 26'h2000000, 1'b0);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (dif.out_valid) break;
            lat++;
        end
        chk("latency", 32'(lat), 32'd26);
        drain(1'b0);

        // Directed values
        send(23'h0, 23'h400000, 1'b0, 26'h1555555, 1'b1);
        drain(1'b0);
        send(23'h7FFFFF, 23'h0, 1'b0, 26'h3FFFFFC, 1'b0);
        drain(1'b0);
        send(23'h0, 23'h7FFFFF, 1'b0, 26'h1000001, 1'b1);
        drain(1'b0);

        // Back-pressure with in_valid noise
        bp = model(23'h2AAAAA, 23'h155555);
        dif.out_ready = 1'b0;
        send(23'h2AAAAA, 23'h155555, 1'b1, '0, 1'b0);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (dif.out_valid) break;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            dif.in_valid = ~dif.in_valid;
            dif.frc_X    = FW'($urandom);
            dif.frc_Y    = FW'($urandom);
            @(negedge clk);
            chk("bp_out_valid", 32'(dif.out_valid), 32'd1);
            chk("bp_in_ready", 32'(dif.in_ready), 32'd0);
            chk("bp_frc_q", 32'(dif.frc_Q), 32'(bp.q));
            chk("bp_sticky", 32'(dif.sticky), 32'(bp.s));
        end
        @(posedge clk);
        #1;
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rel_out_valid", 32'(dif.out_valid), 32'd0);
        chk("rel_in_ready", 32'(dif.in_ready), 32'd1);
        chk("rel_drained", 32'(sb.size()), 32'd0);
        send(23'h13579B, 23'h7ABCDE, 1'b1, '0, 1'b0);
        drain(1'b0);

        // Reset during RUN cycle 10
        send(23'h123456, 23'h654321, 1'b1, '0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_in_ready", 32'(dif.in_ready), 32'd1);
        chk("abort_out_valid", 32'(dif.out_valid), 32'd0);
        seen = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (dif.out_valid) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        send(23'h400000, 23'h400000, 1'b0, 26'h2000000, 1'b0);
        drain(1'b0);

        // Random operands with output stalls
        for (int i = 0; i < 200; i++) begin
            send(FW'($urandom), FW'($urandom), 1'b1, '0, 1'b0);
            drain(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
